cv32e40x_lsu_wr_scoreboard: RTL and testbench

- In-order scoreboard of register-file writes still pending from the LSU (outstanding loads).
- Sits between ID and WB. ID allocates an entry when a load with rd issues. WB retires the oldest entry when its data is written back.
- Drives RAW/WAW hazard stalls and a full stall into the controller, which lets more than one load be in flight without losing hazard coverage.

---
 rtl/cv32e40x_lsu_wr_scoreboard.sv | 110 +++++++++++
 tb/tb_cv32e40x_lsu_wr_scoreboard.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/cv32e40x_lsu_wr_scoreboard.sv
// In-order scoreboard of LSU register-file writes still in flight.
// ID allocates on load issue, WB retires the head; drives RAW/WAW/full stalls.
module cv32e40x_lsu_wr_scoreboard #(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      alloc_i,
    input  logic [ADDR_W-1:0]         alloc_waddr_i,
    output logic                      alloc_ready_o,
    input  logic                      retire_i,
    input  logic [ADDR_W-1:0]         retire_waddr_i,
    input  logic                      flush_i,
    input  logic [1:0]                rf_re_i,
    input  logic [2*ADDR_W-1:0]       rf_raddr_i,
    input  logic                      rf_we_i,
    input  logic [ADDR_W-1:0]         rf_waddr_i,
    output logic                      raw_hz_o,
    output logic                      waw_hz_o,
    output logic                      stall_o,
    output logic [$clog2(DEPTH):0]    count_o,
    output logic                      empty_o,
    output logic                      retire_err_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    logic [DEPTH-1:0]  r_valid;
    logic [ADDR_W-1:0] r_waddr [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_retire_err;

    logic w_can_retire;
    logic w_ready;
    logic w_do_alloc;
    logic w_raw;
    logic w_waw;

    assign w_can_retire = retire_i & (r_count != '0);
    // A retiring head frees a slot in the same cycle, so a full buffer can still accept.
    assign w_ready      = (r_count < DEPTH_C) | w_can_retire;
    assign w_do_alloc   = alloc_i & w_ready;

    always_comb begin
        w_raw = 1'b0;
        w_waw = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (r_valid[i] && (r_waddr[i] != '0)) begin
                for (int unsigned p = 0; p < 2; p++) begin
                    if (rf_re_i[p] && (rf_raddr_i[p*ADDR_W +: ADDR_W] == r_waddr[i]))
                        w_raw = 1'b1;
                end
                if (rf_we_i && (rf_waddr_i == r_waddr[i]))
                    w_waw = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid      <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_retire_err <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++)
                r_waddr[i] <= '0;
        end else if (flush_i) begin
            r_valid  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (retire_i && (r_count == '0))
                r_retire_err <= 1'b1;
            if (w_can_retire) begin
                if (retire_waddr_i != r_waddr[r_rd_ptr])
                    r_retire_err <= 1'b1;
                r_valid[r_rd_ptr] <= 1'b0;
                r_rd_ptr          <= r_rd_ptr + PTR_ONE;
            end
            // Placed after the retire clear so slot reuse when full keeps the new entry valid.
            if (w_do_alloc) begin
                r_valid[r_wr_ptr] <= 1'b1;
                r_waddr[r_wr_ptr] <= alloc_waddr_i;
                r_wr_ptr          <= r_wr_ptr + PTR_ONE;
            end
            if (w_do_alloc && !w_can_retire)
                r_count <= r_count + CNT_ONE;
            else if (w_can_retire && !w_do_alloc)
                r_count <= r_count - CNT_ONE;
        end
    end

    assign alloc_ready_o = w_ready;
    assign raw_hz_o      = w_raw;
    assign waw_hz_o      = w_waw;
    assign stall_o       = w_raw | w_waw | (alloc_i & ~w_ready);
    assign count_o       = r_count;
    assign empty_o       = (r_count == '0);
    assign retire_err_o  = r_retire_err;

endmodule

// File: tb/tb_cv32e40x_lsu_wr_scoreboard.sv
// Self-checking bench: directed scenarios plus random traffic against a queue model.
module tb_cv32e40x_lsu_wr_scoreboard;

    localparam int DEPTH = 2;
    localparam int AW    = 5;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          alloc;
    logic [AW-1:0] alloc_waddr;
    logic          alloc_ready;
    logic          retire;
    logic [AW-1:0] retire_waddr;
    logic          flush;
    logic [1:0]    rf_re;
    logic [2*AW-1:0] rf_raddr;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic          raw_hz, waw_hz, stall, empty, retire_err;
    logic [CW-1:0] count;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    int unsigned mq[$];
    bit          merr;

    always #5 clk = ~clk;

    cv32e40x_lsu_wr_scoreboard #(.DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .alloc_i(alloc), .alloc_waddr_i(alloc_waddr), .alloc_ready_o(alloc_ready),
        .retire_i(retire), .retire_waddr_i(retire_waddr), .flush_i(flush),
        .rf_re_i(rf_re), .rf_raddr_i(rf_raddr), .rf_we_i(rf_we), .rf_waddr_i(rf_waddr),
        .raw_hz_o(raw_hz), .waw_hz_o(waw_hz), .stall_o(stall),
        .count_o(count), .empty_o(empty), .retire_err_o(retire_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit pending(input int unsigned a);
        if (a == 0) return 1'b0;
        foreach (mq[i]) if (mq[i] == a) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drive(input bit al, input int unsigned aw, input bit rt, input int unsigned rw,
                         input bit fl, input logic [1:0] re, input int unsigned rs1,
                         input int unsigned rs2, input bit we, input int unsigned wa);
        alloc = al; alloc_waddr = AW'(aw);
        retire = rt; retire_waddr = AW'(rw);
        flush = fl; rf_re = re;
        rf_raddr = {AW'(rs2), AW'(rs1)};
        rf_we = we; rf_waddr = AW'(wa);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    endtask

    // Called at a negedge with inputs applied: checks outputs, advances the model, crosses one posedge.
    task automatic step();
        bit e_ret, e_rdy, e_raw, e_waw;
        #1;
        e_ret = retire && (mq.size() != 0);
        e_rdy = (mq.size() < DEPTH) || e_ret;
        e_raw = (rf_re[0] && pending(rf_raddr[AW-1:0])) || (rf_re[1] && pending(rf_raddr[2*AW-1:AW]));
        e_waw = rf_we && pending(rf_waddr);
        check("count", count, mq.size());
        check("empty", empty, mq.size() == 0);
        check("err", retire_err, merr);
        check("ready", alloc_ready, e_rdy);
        check("raw", raw_hz, e_raw);
        check("waw", waw_hz, e_waw);
        check("stall", stall, e_raw || e_waw || (alloc && !e_rdy));
        if (flush) begin
            mq.delete();
        end else begin
            if (retire) begin
                if (mq.size() == 0) merr = 1'b1;
                else begin
                    if (mq[0] != retire_waddr) merr = 1'b1;
                    void'(mq.pop_front());
                end
            end
            if (alloc && e_rdy) mq.push_back(alloc_waddr);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        mq.delete();
        merr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        do_reset();

        // Basic alloc/retire and RAW visibility.
        drive(1, 5, 0, 0, 0, 2'b01, 5, 0, 0, 0); step();
        drive(0, 0, 0, 0, 0, 2'b01, 5, 0, 0, 0); step();
        drive(0, 0, 1, 5, 0, 2'b01, 5, 0, 0, 0); step();
        drive(0, 0, 0, 0, 0, 2'b01, 5, 0, 0, 0); step();

        // Full buffer, stall on alloc, slot reuse with simultaneous retire.
        drive(1, 3, 0, 0, 0, 2'b00, 0, 0, 0, 0); step();
        drive(1, 4, 0, 0, 0, 2'b00, 0, 0, 0, 0); step();
        drive(1, 7, 0, 0, 0, 2'b00, 0, 0, 0, 0); step();
        drive(1, 7, 1, 3, 0, 2'b10, 0, 4, 0, 0); step();
        drive(0, 0, 1, 4, 0, 2'b11, 7, 4, 0, 0); step();
        drive(0, 0, 1, 7, 0, 2'b01, 7, 0, 1, 7); step();
        idle(); step();

        // x0 never hazards.
        drive(1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0); step();
        drive(0, 0, 0, 0, 0, 2'b01, 0, 0, 1, 0); step();
        drive(0, 0, 1, 0, 0, 2'b00, 0, 0, 0, 0); step();

        // WAW on pending x9.
        drive(1, 9, 0, 0, 0, 2'b00, 0, 0, 0, 0); step();
        drive(0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 9); step();
        drive(0, 0, 0, 0, 0, 2'b11, 9, 9, 0, 9); step();

        // Flush beats alloc and retire.
        drive(1, 8, 0, 0, 0, 2'b00, 0, 0, 0, 0); step();
        drive(1, 2, 1, 9, 1, 2'b00, 0, 0, 0, 0); step();
        idle(); step();

        // Retire mismatch, then retire while empty; error is sticky.
        drive(1, 5, 0, 0, 0, 2'b00, 0, 0, 0, 0); step();
        drive(0, 0, 1, 6, 0, 2'b00, 0, 0, 0, 0); step();
        drive(0, 0, 1, 1, 0, 2'b00, 0, 0, 0, 0); step();
        drive(1, 6, 0, 0, 1, 2'b00, 0, 0, 0, 0); step();
        idle(); step();

        // Asynchronous reset mid-operation.
        drive(1, 11, 0, 0, 0, 2'b00, 0, 0, 0, 0); step();
        drive(0, 0, 0, 0, 0, 2'b01, 11, 0, 1, 11); step();
        #2 rst = 1'b1;
        #1;
        check("arst_count", count, 0);
        check("arst_empty", empty, 1);
        check("arst_ready", alloc_ready, 1);
        check("arst_err", retire_err, 0);
        check("arst_raw", raw_hz, 0);
        check("arst_waw", waw_hz, 0);
        check("arst_stall", stall, 0);
        mq.delete();
        merr = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        idle();

        // Random traffic with periodic resets so the sticky error stays observable.
        for (int cyc = 0; cyc < 2000; cyc++) begin
            int unsigned rw;
            if (cyc % 100 == 99) do_reset();
            rw = (mq.size() != 0 && $urandom_range(15) != 0) ? mq[0] : $urandom_range(7);
            drive($urandom_range(1), $urandom_range(7), $urandom_range(2) == 0, rw,
                  $urandom_range(31) == 0, 2'($urandom_range(3)), $urandom_range(7),
                  $urandom_range(7), $urandom_range(1), $urandom_range(7));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
